reaction_timer_fsm: RTL and testbench

Control stage directly downstream of the LFSR random number generator. On a start request it pulses `generate_num`, then consumes the fresh 8-bit `random_number` to form a random pre-go delay in milliseconds. After the delay it lights the GO indicator and measures the user's reaction time in milliseconds. It reports a valid result, a false start (press before GO) or a timeout to the display/scoring logic.

---
 rtl/reaction_timer_fsm_if.sv | 31 +++
 rtl/reaction_timer_fsm.sv | 116 +++++++++++
 tb/tb_reaction_timer_fsm.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_fsm_if.sv
// Signal bundle between the reaction timer and its surroundings (LFSR,
// debounced buttons, display/scoring). All DUT outputs are registered or
// decoded from the state register. generate_num is a one-cycle request and
// carries no acknowledge: the LFSR advances at the edge that samples it.
interface reaction_timer_fsm_if;
  logic        start;
  logic        react;
  logic [7:0]  random_number;
  logic        generate_num;
  logic        led_go;
  logic        busy;
  logic [13:0] reaction_ms;
  logic        result_valid;
  logic        false_start;
  logic        timeout;
  logic [2:0]  state_dbg;

  // Timer side
  modport slave (
    input  start, react, random_number,
    output generate_num, led_go, busy, reaction_ms,
           result_valid, false_start, timeout, state_dbg
  );

  // Environment side
  modport master (
    output start, react, random_number,
    input  generate_num, led_go, busy, reaction_ms,
           result_valid, false_start, timeout, state_dbg
  );
endinterface

// File: rtl/reaction_timer_fsm.sv
// Reaction timer: requests a random number, waits a random pre-go delay,
// lights GO and measures the user's reaction time in milliseconds.
// A start seen in IDLE/DONE/FALSE/TMO raises generate_num for one cycle and
// stays in place during that cycle, so the LFSR has advanced when LOAD
// samples random_number on the following cycle.
module reaction_timer_fsm #(
  parameter int TICKS_PER_MS   = 50000,
  parameter int DELAY_BASE_MS  = 1000,
  parameter int DELAY_SCALE_MS = 8,
  parameter int TIMEOUT_MS     = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  reaction_timer_fsm_if.slave   tmr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_GO    = 3'd3,
    S_DONE  = 3'd4,
    S_FALSE = 3'd5,
    S_TMO   = 3'd6
  } state_e;

  localparam int            PW         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [13:0]   TMO_VAL    = 14'(TIMEOUT_MS);
  localparam logic [13:0]   TMO_LAST   = 14'(TIMEOUT_MS - 1);

  state_e        state_q, state_d;
  logic          gen_q, gen_d;
  logic [PW-1:0] presc_q;
  logic [11:0]   delay_q;
  logic [13:0]   ms_q;
  logic [13:0]   rms_q;
  logic          tick;
  logic          timing;

  assign tick   = (presc_q == PRESC_LAST);
  assign timing = (state_q == S_WAIT) || (state_q == S_GO);

  // State register and the registered LFSR request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
    end
  end

  // Next-state logic; react has priority over the coincident final tick
  always_comb begin
    state_d = state_q;
    gen_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FALSE, S_TMO: begin
        if (gen_q)               state_d = S_LOAD;
        else if (tmr.start)      gen_d   = 1'b1;
      end
      S_LOAD:                    state_d = S_WAIT;
      S_WAIT: begin
        if (tmr.react)                      state_d = S_FALSE;
        else if (tick && delay_q == 12'd1)  state_d = S_GO;
      end
      S_GO: begin
        if (tmr.react)                      state_d = S_DONE;
        else if (tick && ms_q == TMO_LAST)  state_d = S_TMO;
      end
      default:                   state_d = S_IDLE;
    endcase
  end

  // Prescaler, delay down-counter, ms up-counter and the result register
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      delay_q <= '0;
      ms_q    <= '0;
      rms_q   <= '0;
    end else begin
      // Restart the ms prescaler whenever WAIT or GO is entered
      if (state_d != state_q || !timing || tick) presc_q <= '0;
      else                                       presc_q <= presc_q + PW'(1);

      if (state_q == S_LOAD)
        delay_q <= 12'(DELAY_BASE_MS + DELAY_SCALE_MS * int'(tmr.random_number));
      else if (state_q == S_WAIT && tick)
        delay_q <= delay_q - 12'd1;

      if (state_q != S_GO) ms_q <= '0;
      else if (tick)       ms_q <= ms_q + 14'd1;

      if (state_q == S_GO) begin
        if (tmr.react)                      rms_q <= ms_q;
        else if (tick && ms_q == TMO_LAST)  rms_q <= TMO_VAL;
      end
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    tmr.generate_num = gen_q;
    tmr.led_go       = (state_q == S_GO);
    tmr.busy         = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_GO);
    tmr.result_valid = (state_q == S_DONE);
    tmr.false_start  = (state_q == S_FALSE);
    tmr.timeout      = (state_q == S_TMO);
    tmr.reaction_ms  = rms_q;
    tmr.state_dbg    = state_q;
  end

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Bench for reaction_timer_fsm. Trials are described by the random number,
// the cycle of the react press and optional stray start pulses; the expected
// GO cycle and result are computed from the timing rules as plain arithmetic.
// Cycle 0 of a trial is the cycle in which generate_num is high.
module tb_reaction_timer_fsm;

  localparam int T  = 4;
  localparam int B  = 2;
  localparam int S  = 1;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reaction_timer_fsm_if b();

  reaction_timer_fsm #(
    .TICKS_PER_MS(T), .DELAY_BASE_MS(B), .DELAY_SCALE_MS(S), .TIMEOUT_MS(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tmr (b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];     // {kind[1:0], reaction_ms[13:0], cycle[15:0]}
  int          exp_go_q[$];  // expected cycle of led_go rising
  int          cyc      = 0;
  int          gen_cyc  = 0;
  int          gen_seen = 0;
  int          exp_gen  = 0;
  int          last_ms  = 0;
  logic        prev_go  = 1'b0;
  logic        prev_flag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [1:0]  kind;
    logic [31:0] obs;
    cyc++;
    if (!rst) begin
      if (b.generate_num) begin
        gen_seen++;
        gen_cyc = cyc;
        check("gen_not_busy", 32'(b.busy), 32'd0);
      end
      if (b.led_go && !prev_go) begin
        if (exp_go_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_go: led_go rose at trial cycle %0d, none expected", cyc - gen_cyc);
        end else begin
          check("go_cycle", 32'(cyc - gen_cyc), 32'(exp_go_q.pop_front()));
        end
      end
      kind = b.result_valid ? 2'd1 : b.false_start ? 2'd2 : b.timeout ? 2'd3 : 2'd0;
      if (kind != 2'd0 && !prev_flag) begin
        obs = {kind, b.reaction_ms, 16'(cyc - gen_cyc)};
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result: got %0h, none expected", obs);
        end else begin
          check("result", obs, exp_q.pop_front());
        end
      end
    end
    prev_go   = b.led_go;
    prev_flag = b.result_valid | b.false_start | b.timeout;
  end

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gen"},   32'(b.generate_num), 32'd0);
    check({tag, "_go"},    32'(b.led_go),       32'd0);
    check({tag, "_busy"},  32'(b.busy),         32'd0);
    check({tag, "_ms"},    32'(b.reaction_ms),  32'(last_ms));
    check({tag, "_valid"}, 32'(b.result_valid), 32'd0);
    check({tag, "_false"}, 32'(b.false_start),  32'd0);
    check({tag, "_tmo"},   32'(b.timeout),      32'd0);
    check({tag, "_state"}, 32'(b.state_dbg),    32'd0);
  endtask

  // rc < 0: no press; rst_at >= 0: reset pulse during that trial cycle
  task automatic run_trial(input int r, input int rc, input bit extra, input int rst_at);
    int go, tmo, res_c, end_c, ms;
    logic [1:0] kind;
    go  = 2 + (B + r * S) * T;
    tmo = go + TO * T;
    ms  = last_ms;
    if (rst_at >= 0) begin
      kind  = 2'd0;
      res_c = rst_at;
    end else if (rc >= 2 && rc < go) begin
      kind  = 2'd2;
      res_c = rc + 1;
    end else if (rc >= go && rc < tmo) begin
      kind  = 2'd1;
      res_c = rc + 1;
      ms    = (rc - go) / T;
    end else begin
      kind  = 2'd3;
      res_c = tmo;
      ms    = TO;
    end
    if (kind != 2'd2 && (rst_at < 0 || rst_at >= go)) exp_go_q.push_back(go);
    if (kind != 2'd0) exp_q.push_back({kind, 14'(ms), 16'(res_c)});
    exp_gen++;
    end_c = res_c;

    // start is sampled by the edge that begins cycle 0
    b.start = 1'b1;
    b.random_number = 8'($urandom);
    next_cycle();
    b.start = 1'b0;
    for (int k = 0; k <= end_c + 1; k++) begin
      b.random_number = (k == 1) ? 8'(r) : 8'($urandom);
      b.react = (k == rc);
      b.start = extra && k >= 2 && k <= end_c - 2 && $urandom_range(0, 5) == 0;
      if (k == rst_at) rst = 1'b1;
      if (k == 1) begin
        @(negedge clk);
        check("load_busy",  32'(b.busy),         32'd1);
        check("load_flags", 32'({b.result_valid, b.false_start, b.timeout}), 32'd0);
        check("load_ms",    32'(b.reaction_ms),  32'(last_ms));
      end
      next_cycle();
      b.react = 1'b0;
      b.start = 1'b0;
      if (k == rst_at) begin
        rst = 1'b0;
        last_ms = 0;
        @(negedge clk);
        check_idle_outputs("midreset");
        break;
      end
    end
    if (kind != 2'd0) last_ms = ms;
    next_cycle();
    check("trial_results_drained", 32'(exp_q.size()),    32'd0);
    check("trial_go_drained",      32'(exp_go_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, go, rc;
    b.start = 1'b0;
    b.react = 1'b0;
    b.random_number = 8'd0;

    // Reset held for three cycles, then stray presses in IDLE
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      b.react = 1'b1;
      next_cycle();
      b.react = 1'b0;
    end
    @(negedge clk);
    check_idle_outputs("idle_react");

    // Directed trials
    run_trial(5, 43, 1'b0, -1);   // DONE, 3 ms, GO at 30
    run_trial(5, 15, 1'b0, -1);   // false start during WAIT
    run_trial(5, 29, 1'b0, -1);   // press on the final WAIT tick
    run_trial(0, -1, 1'b0, -1);   // timeout, 20 ms
    run_trial(0, 89, 1'b0, -1);   // press on the timeout tick -> 19 ms
    run_trial(5, 43, 1'b1, -1);   // stray starts in WAIT/GO are ignored
    run_trial(5, 15, 1'b1, -1);   // reaction_ms holds through a false start
    run_trial(3, -1, 1'b0, 30);   // reset during GO
    run_trial(1, 20, 1'b0, -1);   // clean trial after reset

    // Randomized trials
    for (int i = 0; i < 14; i++) begin
      r  = $urandom_range(0, 60);
      go = 2 + (B + r * S) * T;
      case ($urandom_range(0, 3))
        0:       rc = -1;
        1:       rc = $urandom_range(1, go - 1);
        default: rc = $urandom_range(go, go + TO * T + 4);
      endcase
      run_trial(r, rc, 1'($urandom_range(0, 1)), -1);
    end

    repeat (3) next_cycle();
    check("gen_pulse_count", 32'(gen_seen), 32'(exp_gen));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
